// File: rtl/snapshot_trigger_ctrl.sv
// Snapshot trigger sequencer: arm -> pre-fill -> qualified trigger -> post-fill -> readout -> holdoff.
// Optional macro SNAPSHOT_TRIG_TIMEOUT_EN adds an ARMED self-trigger timeout (timeout_beats/timeout_flag).
//
// state       | meaning
// IDLE        | waiting for arm
// PRE_FILL    | counting PRE_BEATS valid beats into the snapshot
// ARMED       | accepting qualified trigger requests
// FIRE        | trig_out high, waiting for the handshake beat
// POST        | counting POST_BEATS valid beats after the trigger beat
// WAIT_READ   | waiting for readout_done
// HOLDOFF     | counting HOLDOFF_BEATS valid beats before re-arm is possible
module snapshot_trigger_ctrl #(
    parameter int PWR_W         = 32,
    parameter int PRE_BEATS     = 512,
    parameter int POST_BEATS    = 512,
    parameter int HOLDOFF_BEATS = 1024,
    parameter int TS_W          = 48,
    parameter int CNT_W         = 16
) (
    input  logic             clk_data,
    input  logic             rst,
    input  logic             data_in_valid,
    input  logic             arm,
    input  logic             force_trig,
    input  logic             ext_trig,
    input  logic             det_valid,
    input  logic [PWR_W-1:0] det_power,
    input  logic [PWR_W-1:0] threshold,
    input  logic [2:0]       src_mask,
    input  logic             readout_done,
`ifdef SNAPSHOT_TRIG_TIMEOUT_EN
    input  logic [31:0]      timeout_beats,
    output logic             timeout_flag,
`endif
    output logic             trig_out,
    output logic             armed,
    output logic             busy,
    output logic [1:0]       trig_src,
    output logic [TS_W-1:0]  trig_timestamp,
    output logic [15:0]      trig_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE_FILL, S_ARMED, S_FIRE, S_POST, S_WAIT_READ, S_HOLDOFF
    } state_t;

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_BEATS - 1);
    localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_BEATS - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_BEATS - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TS_W-1:0]   ts_q;
    logic              ext_q;
    logic              trig_out_q;
    logic [1:0]        trig_src_q, trig_src_d;
    logic [TS_W-1:0]   trig_ts_q, trig_ts_d;
    logic [15:0]       trig_count_q, trig_count_d;
    logic [1:0]        req_src;

`ifdef SNAPSHOT_TRIG_TIMEOUT_EN
    logic [31:0]       tmo_q;
    logic              tmo_flag_q, tmo_flag_d;
    logic              tmo_hit;

    assign tmo_hit = data_in_valid && (timeout_beats != 32'd0) &&
                     (tmo_q == timeout_beats - 32'd1);
`endif

    // Priority force > ext > det; 0 means no request this cycle.
    always_comb begin
        req_src = 2'd0;
        if (force_trig && src_mask[0])
            req_src = 2'd1;
        else if (ext_trig && !ext_q && src_mask[1])
            req_src = 2'd2;
        else if (det_valid && src_mask[2] && (det_power >= threshold))
            req_src = 2'd3;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        trig_src_d   = trig_src_q;
        trig_ts_d    = trig_ts_q;
        trig_count_d = trig_count_q;
`ifdef SNAPSHOT_TRIG_TIMEOUT_EN
        tmo_flag_d   = tmo_flag_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d = S_PRE_FILL;
                    cnt_d   = '0;
`ifdef SNAPSHOT_TRIG_TIMEOUT_EN
                    tmo_flag_d = 1'b0;
`endif
                end
            end
            S_PRE_FILL: begin
                if (data_in_valid) begin
                    if (cnt_q == PRE_LAST) begin
                        // A request on the final pre-fill beat is honoured directly.
                        if (req_src != 2'd0) begin
                            state_d    = S_FIRE;
                            trig_src_d = req_src;
                        end else begin
                            state_d = S_ARMED;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_ARMED: begin
                if (req_src != 2'd0) begin
                    state_d    = S_FIRE;
                    trig_src_d = req_src;
                end
`ifdef SNAPSHOT_TRIG_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d    = S_FIRE;
                    trig_src_d = 2'd1;
                    tmo_flag_d = 1'b1;
                end
`endif
            end
            S_FIRE: begin
                if (data_in_valid) begin
                    trig_ts_d = ts_q;
                    if (trig_count_q != 16'hFFFF)
                        trig_count_d = trig_count_q + 16'd1;
                    state_d = S_POST;
                    cnt_d   = '0;
                end
            end
            S_POST: begin
                if (data_in_valid) begin
                    if (cnt_q == POST_LAST)
                        state_d = S_WAIT_READ;
                    else
                        cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_READ: begin
                if (readout_done) begin
                    cnt_d   = '0;
                    state_d = (HOLDOFF_BEATS == 0) ? S_IDLE : S_HOLDOFF;
                end
            end
            S_HOLDOFF: begin
                if (data_in_valid) begin
                    if (cnt_q == HOLD_LAST)
                        state_d = S_IDLE;
                    else
                        cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_data) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            ts_q         <= '0;
            ext_q        <= 1'b0;
            trig_out_q   <= 1'b0;
            trig_src_q   <= 2'd0;
            trig_ts_q    <= '0;
            trig_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ext_q        <= ext_trig;
            trig_out_q   <= (state_d == S_FIRE);
            trig_src_q   <= trig_src_d;
            trig_ts_q    <= trig_ts_d;
            trig_count_q <= trig_count_d;
            if (data_in_valid)
                ts_q <= ts_q + 1'b1;
        end
    end

`ifdef SNAPSHOT_TRIG_TIMEOUT_EN
    always_ff @(posedge clk_data) begin
        if (rst) begin
            tmo_q      <= 32'd0;
            tmo_flag_q <= 1'b0;
        end else begin
            tmo_flag_q <= tmo_flag_d;
            if (state_q != S_ARMED)
                tmo_q <= 32'd0;
            else if (data_in_valid)
                tmo_q <= tmo_q + 32'd1;
        end
    end

    assign timeout_flag = tmo_flag_q;
`endif

    assign trig_out       = trig_out_q;
    assign armed          = (state_q == S_ARMED);
    assign busy           = (state_q != S_IDLE);
    assign trig_src       = trig_src_q;
    assign trig_timestamp = trig_ts_q;
    assign trig_count     = trig_count_q;

endmodule

// File: tb/tb_snapshot_trigger_ctrl.sv
// Bench for snapshot_trigger_ctrl: vector table, directed corner sequences and a
// randomized run checked cycle-by-cycle against a beats-remaining reference model.
module tb_snapshot_trigger_ctrl;

    localparam int PRE_B  = 512;
    localparam int POST_B = 512;
    localparam int HOLD_B = 1024;

    logic        clk_data = 1'b0;
    logic        rst = 1'b1;
    logic        data_in_valid = 1'b0, arm = 1'b0, force_trig = 1'b0, ext_trig = 1'b0;
    logic        det_valid = 1'b0, readout_done = 1'b0;
    logic [31:0] det_power = '0, threshold = '0;
    logic [2:0]  src_mask = '0;
    logic        trig_out, armed, busy;
    logic [1:0]  trig_src;
    logic [47:0] trig_timestamp;
    logic [15:0] trig_count;
`ifdef SNAPSHOT_TRIG_TIMEOUT_EN
    logic [31:0] timeout_beats = '0;
    logic        timeout_flag;
`endif

    snapshot_trigger_ctrl dut (
        .clk_data(clk_data), .rst(rst), .data_in_valid(data_in_valid), .arm(arm),
        .force_trig(force_trig), .ext_trig(ext_trig), .det_valid(det_valid),
        .det_power(det_power), .threshold(threshold), .src_mask(src_mask),
        .readout_done(readout_done),
`ifdef SNAPSHOT_TRIG_TIMEOUT_EN
        .timeout_beats(timeout_beats), .timeout_flag(timeout_flag),
`endif
        .trig_out(trig_out), .armed(armed), .busy(busy), .trig_src(trig_src),
        .trig_timestamp(trig_timestamp), .trig_count(trig_count)
    );

    always #5 clk_data = ~clk_data;

    int checks = 0, passes = 0, mon_fails = 0;
    logic mon_en = 1'b0;
    int exp_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_data);
            #1;
        end
    endtask

    // Reference model: phases with a count of beats still to go.
    localparam int P_IDLE = 0, P_PRE = 1, P_ARMED = 2, P_FIRE = 3, P_POST = 4, P_WRD = 5, P_HOLD = 6;
    int          m_phase = P_IDLE, m_left = 0;
    logic [47:0] m_ts = '0, m_tstamp = '0;
    logic        m_ext = 1'b0, m_out = 1'b0, m_flag = 1'b0;
    logic [1:0]  m_src = '0;
    logic [15:0] m_count = '0;
    int unsigned m_tmo = 0;

    initial forever begin
        logic [1:0] r;
        logic [31:0] tb_lim;
        @(posedge clk_data);
        tb_lim = 32'd0;
`ifdef SNAPSHOT_TRIG_TIMEOUT_EN
        tb_lim = timeout_beats;
`endif
        if (rst) begin
            m_phase = P_IDLE; m_left = 0; m_ts = '0; m_tstamp = '0; m_ext = 1'b0;
            m_out = 1'b0; m_flag = 1'b0; m_src = '0; m_count = '0; m_tmo = 0;
        end else begin
            r = 2'd0;
            if (force_trig && src_mask[0]) r = 2'd1;
            else if (ext_trig && !m_ext && src_mask[1]) r = 2'd2;
            else if (det_valid && src_mask[2] && det_power >= threshold) r = 2'd3;
            case (m_phase)
                P_IDLE: if (arm) begin m_phase = P_PRE; m_left = PRE_B; m_flag = 1'b0; end
                P_PRE: if (data_in_valid) begin
                    m_left--;
                    if (m_left == 0) begin
                        if (r != 0) begin m_phase = P_FIRE; m_src = r; end
                        else begin m_phase = P_ARMED; m_tmo = 0; end
                    end
                end
                P_ARMED: begin
                    if (r != 0) begin m_phase = P_FIRE; m_src = r; end
                    else if (data_in_valid && tb_lim != 0 && m_tmo + 1 == tb_lim) begin
                        m_phase = P_FIRE; m_src = 2'd1; m_flag = 1'b1;
                    end else if (data_in_valid) m_tmo++;
                end
                P_FIRE: if (data_in_valid) begin
                    m_tstamp = m_ts;
                    if (m_count != 16'hFFFF) m_count++;
                    m_phase = P_POST; m_left = POST_B;
                end
                P_POST: if (data_in_valid) begin
                    m_left--;
                    if (m_left == 0) m_phase = P_WRD;
                end
                P_WRD: if (readout_done) begin
                    if (HOLD_B == 0) m_phase = P_IDLE;
                    else begin m_phase = P_HOLD; m_left = HOLD_B; end
                end
                default: if (data_in_valid) begin
                    m_left--;
                    if (m_left == 0) m_phase = P_IDLE;
                end
            endcase
            if (data_in_valid) m_ts++;
            m_ext = ext_trig;
            m_out = (m_phase == P_FIRE);
        end
    end

    initial forever begin
        logic ok;
        @(negedge clk_data);
        if (mon_en && mon_fails < 20) begin
            checks++;
            ok = (trig_out === m_out) && (armed === (m_phase == P_ARMED)) &&
                 (busy === (m_phase != P_IDLE)) && (trig_src === m_src) &&
                 (trig_timestamp === m_tstamp) && (trig_count === m_count);
`ifdef SNAPSHOT_TRIG_TIMEOUT_EN
            ok = ok && (timeout_flag === m_flag);
`endif
            if (ok) passes++;
            else begin
                mon_fails++;
                $display("FAIL model_compare t=%0t: got out=%b armed=%b busy=%b src=%0d ts=%0h cnt=%0d, expected out=%b armed=%b busy=%b src=%0d ts=%0h cnt=%0d",
                         $time, trig_out, armed, busy, trig_src, trig_timestamp, trig_count,
                         m_out, m_phase == P_ARMED, m_phase != P_IDLE, m_src, m_tstamp, m_count);
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1);
    end

    task automatic arm_to_armed(input string tag);
        int n = 0;
        arm = 1'b1; cyc(1); arm = 1'b0;
        while (!armed && n < 2000) begin cyc(1); n++; end
        check(tag, 64'(n), 64'(PRE_B));
    endtask

    // From the cycle after the handshake: early readout, arm in WAIT_READ, readout, holdoff.
    task automatic finish_capture(input string tag);
        int n = 0;
        cyc(10);
        readout_done = 1'b1; cyc(1); readout_done = 1'b0;
        cyc(POST_B);
        arm = 1'b1; cyc(1); arm = 1'b0;
        cyc(20);
        check({tag, "_wait_read_busy"}, 64'(busy), 64'd1);
        check({tag, "_wait_read_arm_ignored"}, 64'(armed), 64'd0);
        readout_done = 1'b1; cyc(1); readout_done = 1'b0;
        while (busy && n < 3000) begin cyc(1); n++; end
        check({tag, "_holdoff_beats"}, 64'(n), 64'(HOLD_B));
    endtask

    typedef struct {
        logic [2:0]  mask;
        logic        f, e, d;
        logic [31:0] pwr, thr;
        logic        exp_trig;
        logic [1:0]  exp_src;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vector(input int i, input vec_t v);
        src_mask = v.mask; force_trig = v.f; ext_trig = v.e; det_valid = v.d;
        det_power = v.pwr; threshold = v.thr;
        cyc(1);
        force_trig = 1'b0; ext_trig = 1'b0; det_valid = 1'b0;
        check($sformatf("vec%0d_trig_out", i), 64'(trig_out), 64'(v.exp_trig));
        if (v.exp_trig) begin
            check($sformatf("vec%0d_trig_src", i), 64'(trig_src), 64'(v.exp_src));
        end else begin
            check($sformatf("vec%0d_still_armed", i), 64'(armed), 64'd1);
            src_mask = 3'b001; force_trig = 1'b1; cyc(1); force_trig = 1'b0;
            check($sformatf("vec%0d_forced_trig", i), 64'(trig_out), 64'd1);
        end
        cyc(1);
        exp_cnt++;
        check($sformatf("vec%0d_trig_count", i), 64'(trig_count), 64'(exp_cnt));
        check($sformatf("vec%0d_trig_out_drop", i), 64'(trig_out), 64'd0);
        finish_capture($sformatf("vec%0d", i));
    endtask

    initial begin
        int n, hi;
        logic saw;
        logic [47:0] exp_ts;

        vecs[0] = '{3'b111, 1'b1, 1'b1, 1'b1, 32'd100, 32'd50, 1'b1, 2'd1};
        vecs[1] = '{3'b110, 1'b1, 1'b1, 1'b1, 32'd100, 32'd50, 1'b1, 2'd2};
        vecs[2] = '{3'b100, 1'b1, 1'b1, 1'b1, 32'd100, 32'd50, 1'b1, 2'd3};
        vecs[3] = '{3'b100, 1'b0, 1'b0, 1'b1, 32'd50,  32'd50, 1'b1, 2'd3};
        vecs[4] = '{3'b100, 1'b0, 1'b0, 1'b1, 32'd49,  32'd50, 1'b0, 2'd0};
        vecs[5] = '{3'b011, 1'b0, 1'b0, 1'b1, 32'd100, 32'd50, 1'b0, 2'd0};
        vecs[6] = '{3'b010, 1'b0, 1'b1, 1'b0, 32'd0,   32'd50, 1'b1, 2'd2};
        vecs[7] = '{3'b000, 1'b1, 1'b1, 1'b1, 32'd100, 32'd50, 1'b0, 2'd0};

        cyc(3);
        mon_en = 1'b1;
        check("reset_trig_out", 64'(trig_out), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_trig_count", 64'(trig_count), 64'd0);
        check("reset_trig_timestamp", 64'(trig_timestamp), 64'd0);
        check("reset_trig_src", 64'(trig_src), 64'd0);
        rst = 1'b0;

        // Pre-fill length and forced requests before the final pre-fill beat.
        data_in_valid = 1'b1; src_mask = 3'b001;
        arm = 1'b1; cyc(1); arm = 1'b0;
        n = 0; saw = 1'b0;
        while (!armed && n < 2000) begin
            force_trig = (n == 100 || n == 510);
            cyc(1); n++;
            force_trig = 1'b0;
            if (trig_out) saw = 1'b1;
        end
        check("prefill_beats_to_armed", 64'(n), 64'(PRE_B));
        check("prefill_force_ignored", 64'(saw), 64'd0);

        for (int i = 0; i < 8; i++) begin
            if (i > 0) arm_to_armed($sformatf("vec%0d_prefill", i));
            run_vector(i, vecs[i]);
        end

        // Request on the final pre-fill beat.
        src_mask = 3'b001;
        arm = 1'b1; cyc(1); arm = 1'b0;
        cyc(PRE_B - 1);
        force_trig = 1'b1; cyc(1); force_trig = 1'b0;
        check("last_prefill_trig_out", 64'(trig_out), 64'd1);
        check("last_prefill_not_armed", 64'(armed), 64'd0);
        check("last_prefill_src", 64'(trig_src), 64'd1);
        cyc(1); exp_cnt++;
        check("last_prefill_count", 64'(trig_count), 64'(exp_cnt));
        finish_capture("last_prefill");

        // Det trigger while data_in_valid is low: trig_out holds until the first valid beat.
        arm_to_armed("stall_prefill");
        src_mask = 3'b100; det_power = 32'd100; threshold = 32'd50;
        det_valid = 1'b1; data_in_valid = 1'b0;
        cyc(1); det_valid = 1'b0;
        hi = int'(trig_out);
        repeat (4) begin cyc(1); hi += int'(trig_out); end
        check("stall_trig_out_held", 64'(hi), 64'd5);
        exp_ts = m_ts;
        data_in_valid = 1'b1; cyc(1); exp_cnt++;
        check("stall_trig_out_drop", 64'(trig_out), 64'd0);
        check("stall_trig_timestamp", 64'(trig_timestamp), 64'(exp_ts));
        check("stall_trig_count", 64'(trig_count), 64'(exp_cnt));
        check("stall_trig_src", 64'(trig_src), 64'd3);
        finish_capture("stall");

        // Reset in FIRE, then in POST.
        arm_to_armed("rst_fire_prefill");
        src_mask = 3'b001; data_in_valid = 1'b0;
        force_trig = 1'b1; cyc(1); force_trig = 1'b0;
        check("rst_fire_trig_out_before", 64'(trig_out), 64'd1);
        rst = 1'b1; cyc(1); rst = 1'b0;
        check("rst_fire_trig_out", 64'(trig_out), 64'd0);
        check("rst_fire_busy", 64'(busy), 64'd0);
        data_in_valid = 1'b1;
        arm_to_armed("rst_post_prefill");
        force_trig = 1'b1; cyc(1); force_trig = 1'b0;
        cyc(1);
        check("rst_post_count_before", 64'(trig_count), 64'd1);
        cyc(20);
        rst = 1'b1; cyc(1); rst = 1'b0;
        check("rst_post_busy", 64'(busy), 64'd0);
        check("rst_post_trig_count", 64'(trig_count), 64'd0);
        check("rst_post_trig_timestamp", 64'(trig_timestamp), 64'd0);
        check("rst_post_trig_src", 64'(trig_src), 64'd0);
        arm_to_armed("rearm_after_rst");

`ifdef SNAPSHOT_TRIG_TIMEOUT_EN
        src_mask = 3'b000; timeout_beats = 32'd100;
        n = 0;
        while (!trig_out && n < 1000) begin cyc(1); n++; end
        check("timeout_beats", 64'(n), 64'd100);
        check("timeout_src", 64'(trig_src), 64'd1);
        check("timeout_flag_set", 64'(timeout_flag), 64'd1);
        cyc(1);
        finish_capture("timeout");
        timeout_beats = 32'd0;
        arm_to_armed("timeout_rearm");
        check("timeout_flag_cleared", 64'(timeout_flag), 64'd0);
`endif

        // Randomized run against the reference model.
        for (int c = 0; c < 15000; c++) begin
            data_in_valid = ($urandom_range(3) != 0);
            arm           = ($urandom_range(39) == 0);
            force_trig    = ($urandom_range(299) == 0);
            if ($urandom_range(29) == 0) ext_trig = ~ext_trig;
            det_valid     = ($urandom_range(1) == 1);
            det_power     = $urandom_range(255);
            threshold     = 32'd240;
            readout_done  = ($urandom_range(99) == 0);
            rst           = ($urandom_range(4999) == 0);
            if (c % 1000 == 0) src_mask = 3'($urandom_range(7));
`ifdef SNAPSHOT_TRIG_TIMEOUT_EN
            if (c % 3000 == 0) timeout_beats = ($urandom_range(1) == 1) ? $urandom_range(300, 20) : 32'd0;
`endif
            cyc(1);
        end
        rst = 1'b0; arm = 1'b0; force_trig = 1'b0; det_valid = 1'b0; readout_done = 1'b0;
        cyc(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/snapshot_trigger_ctrl.md
Name: snapshot_trigger_ctrl

Overview:
- Sequences one snapshot capture per arm request.
- Waits for the snapshot pre-trigger half to fill, then qualifies trigger sources and issues a single trigger pulse aligned to a valid beat.
- Tracks post-trigger fill and readout completion, then applies a re-arm holdoff.
- Sits in the clk_data domain between the detection pipeline/register block and the snapshot capture block.

Parameters:
- PWR_W, 32: width of the detection power and threshold.
- PRE_BEATS, 512: valid beats required before triggers are accepted (snapshot depth/2).
- POST_BEATS, 512: valid beats after the trigger beat until the capture is complete.
- HOLDOFF_BEATS, 1024: valid beats in HOLDOFF before returning to IDLE.
- TS_W, 48: width of the valid-beat timestamp counter.
- CNT_W, 16: width of the counters that size PRE/POST/HOLDOFF (must hold max(param)).

Ports:
- clk_data  in  1  data clock
- rst  in  1  synchronous, active-high reset
- data_in_valid  in  1  datapath beat strobe; all beat counting uses it
- arm  in  1  single-cycle arm request (register block, already in clk_data)
- force_trig  in  1  software trigger pulse
- ext_trig  in  1  external trigger level, edge-detected internally
- det_valid  in  1  detection sample valid
- det_power  in  PWR_W  detection power, unsigned
- threshold  in  PWR_W  trigger threshold, unsigned
- src_mask  in  3  per-source enable {det, ext, force}
- readout_done  in  1  pulse when software has drained the snapshot FIFO
- trig_out  out  1  trigger to snapshot block
- armed  out  1  high in ARMED
- busy  out  1  high in any state other than IDLE
- trig_src  out  2  source of the last trigger: 0 none, 1 force, 2 ext, 3 det
- trig_timestamp  out  TS_W  timestamp latched at the trigger beat
- trig_count  out  16  accepted triggers, saturating at 0xFFFF

Behaviour:
- Reset: state IDLE; all outputs 0; ts_cnt 0; ext edge register 0; pending-trigger flag cleared.
- ts_cnt: free-running; +1 on each data_in_valid; wraps modulo 2^TS_W.
- ext edge: ext_rise = ext_trig & ~ext_trig_q.
- Trigger request, evaluated in ARMED each cycle:
  - force: force_trig & src_mask[0]
  - ext: ext_rise & src_mask[1]
  - det: det_valid & src_mask[2] & (det_power >= threshold)
  - Priority force > ext > det; only the winning source is recorded.
- Sources are ignored outside ARMED, except a request in the last PRE_FILL cycle. Requests never queue across states.
- States and transitions:
  - IDLE: arm -> PRE_FILL, beat counter cleared.
  - PRE_FILL: counter +1 per valid beat; at count == PRE_BEATS-1 with valid -> ARMED.
  - ARMED: armed=1. On a request, latch trig_src, enter FIRE, assert trig_out the next cycle.
  - FIRE: trig_out held high until a cycle with data_in_valid=1 (the handshake beat). On that beat:
    - trig_timestamp <= ts_cnt (pre-increment value)
    - trig_count +1 (saturating)
    - trig_out drops the next cycle
    - -> POST, counter cleared
  - POST: counter +1 per valid beat; at POST_BEATS-1 -> WAIT_READ.
  - WAIT_READ: waits for readout_done -> HOLDOFF, counter cleared. An early readout_done (in any other state) is ignored.
  - HOLDOFF: counter +1 per valid beat; at HOLDOFF_BEATS-1 -> IDLE. HOLDOFF_BEATS=0 means an immediate return.
- trig_out is high for at least 1 cycle. It is never high outside FIRE and the cycle immediately after the handshake.
- arm while busy: ignored, no effect.
- data_in_valid low: all beat counters freeze; FIRE keeps trig_out asserted.
- Simultaneous requests from multiple sources: one trigger, highest priority recorded.
- Reset mid-operation: immediate return to IDLE; trig_out deasserts the next cycle; trig_count and trig_timestamp clear.
- Counters compare with ==. Widths are truncated to CNT_W with no overflow checks, so parameters must fit.

Optional Feature:
- Macro SNAPSHOT_TRIG_TIMEOUT_EN.
- Defined:
  - Adds input timeout_beats [31:0] (0 = disabled).
  - In ARMED, counts valid beats. On reaching timeout_beats with no request, self-triggers as force with trig_src=1.
  - Adds output timeout_flag: set on a timeout trigger, cleared on the next arm.
- Undefined: no port, no counter; ARMED waits indefinitely.

Test Plan:
- rst, arm, data_in_valid continuous, PRE_BEATS=512 -> armed rises exactly 512 valid beats after arm; force_trig before that gives no trig_out.
- Armed, force_trig + ext rise + det_power=100 >= threshold=50 in the same cycle -> one trig_out, trig_src=1, trig_count=1.
- Armed, det trigger, data_in_valid low for 5 cycles -> trig_out held 5+ cycles, drops the cycle after the first valid; trig_timestamp equals ts_cnt at that beat.
- Complete POST, no readout_done -> stays in WAIT_READ, arm ignored; readout_done -> HOLDOFF; idle after 1024 valid beats.
- rst asserted in POST -> next cycle IDLE, busy=0, trig_count=0; a new arm restarts PRE_FILL from 0.
- With SNAPSHOT_TRIG_TIMEOUT_EN, timeout_beats=100, no sources -> trig_out on the 100th armed valid beat, trig_src=1, timeout_flag=1.
